// File: rtl/eeprom_rd_checker_if.sv
// Read-back checker bus: sequencer arm/status plus the driver's read-data stream.
// master = sequencer/driver side, slave = checker.
interface eeprom_rd_checker_if #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_LEN_WIDTH  = 8
);
  logic                    i_chk_start;
  logic [P_DATA_WIDTH-1:0] i_chk_seed;
  logic [P_LEN_WIDTH-1:0]  i_chk_len;
  logic                    o_chk_ready;
  logic [P_DATA_WIDTH-1:0] i_read_data;
  logic                    i_read_valid;
  logic                    o_chk_done;
  logic                    o_chk_pass;
  logic                    o_chk_timeout;
  logic [P_LEN_WIDTH-1:0]  o_chk_err_cnt;
  logic [P_LEN_WIDTH-1:0]  o_chk_first_err_idx;

  modport master (
    output i_chk_start, i_chk_seed, i_chk_len, i_read_data, i_read_valid,
    input  o_chk_ready, o_chk_done, o_chk_pass, o_chk_timeout,
           o_chk_err_cnt, o_chk_first_err_idx
  );

  modport slave (
    input  i_chk_start, i_chk_seed, i_chk_len, i_read_data, i_read_valid,
    output o_chk_ready, o_chk_done, o_chk_pass, o_chk_timeout,
           o_chk_err_cnt, o_chk_first_err_idx
  );
endinterface

// File: rtl/eeprom_rd_checker.sv
// Checks an EEPROM read-back burst against an incrementing pattern from a seed.
// state | meaning
// IDLE  | ready for arm, read bytes ignored
// RUN   | comparing bytes, inter-byte timer running
// DONE  | one-cycle completion pulse, status valid
module eeprom_rd_checker #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_LEN_WIDTH  = 8,
  parameter int P_TIMEOUT    = 4096
) (
  input logic i_clk,
  input logic i_rst,
  eeprom_rd_checker_if.slave chk
);

  localparam int TW = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [P_LEN_WIDTH-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [P_DATA_WIDTH-1:0] expected;
  logic [P_LEN_WIDTH-1:0]  len_q;
  logic [P_LEN_WIDTH-1:0]  index;
  logic [TW-1:0]           timer;

  logic                    mismatch;
  logic                    last_byte;

  assign mismatch  = (chk.i_read_data != expected);
  assign last_byte = (index == (len_q - P_LEN_WIDTH'(1)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                   <= IDLE;
      expected                <= '0;
      len_q                   <= '0;
      index                   <= '0;
      timer                   <= '0;
      chk.o_chk_ready         <= 1'b1;
      chk.o_chk_done          <= 1'b0;
      chk.o_chk_pass          <= 1'b0;
      chk.o_chk_timeout       <= 1'b0;
      chk.o_chk_err_cnt       <= '0;
      chk.o_chk_first_err_idx <= '0;
    end else begin
      chk.o_chk_done <= 1'b0;
      case (state)
        IDLE: begin
          if (chk.i_chk_start) begin
            expected                <= chk.i_chk_seed;
            len_q                   <= chk.i_chk_len;
            index                   <= '0;
            timer                   <= '0;
            chk.o_chk_ready         <= 1'b0;
            chk.o_chk_pass          <= 1'b0;
            chk.o_chk_timeout       <= 1'b0;
            chk.o_chk_err_cnt       <= '0;
            chk.o_chk_first_err_idx <= '0;
            if (chk.i_chk_len == '0) begin
              state          <= DONE;
              chk.o_chk_done <= 1'b1;
              chk.o_chk_pass <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (chk.i_read_valid) begin
            // a byte on the threshold cycle beats the timeout
            timer    <= '0;
            expected <= expected + P_DATA_WIDTH'(1);
            index    <= index + P_LEN_WIDTH'(1);
            if (mismatch) begin
              if (chk.o_chk_err_cnt != ERR_MAX)
                chk.o_chk_err_cnt <= chk.o_chk_err_cnt + P_LEN_WIDTH'(1);
              if (chk.o_chk_err_cnt == '0)
                chk.o_chk_first_err_idx <= index;
            end
            if (last_byte) begin
              state          <= DONE;
              chk.o_chk_done <= 1'b1;
              chk.o_chk_pass <= !mismatch && (chk.o_chk_err_cnt == '0);
            end
          end else if (timer == TMR_LAST) begin
            state             <= DONE;
            chk.o_chk_done    <= 1'b1;
            chk.o_chk_timeout <= 1'b1;
            chk.o_chk_pass    <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        DONE: begin
          state           <= IDLE;
          chk.o_chk_ready <= 1'b1;
        end

        default: begin
          state           <= IDLE;
          chk.o_chk_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_rd_checker.sv
// Directed bench for eeprom_rd_checker: clean, wrap, errors, saturation-size burst,
// timeout boundary, zero length, ignored inputs and mid-run reset.
module tb_eeprom_rd_checker;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eeprom_rd_checker_if #(.P_DATA_WIDTH(8), .P_LEN_WIDTH(8)) bus ();

  eeprom_rd_checker #(.P_DATA_WIDTH(8), .P_LEN_WIDTH(8), .P_TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .chk   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] arr [256];
  logic [7:0] seed_m;
  int         err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] seed, input logic [7:0] len);
    seed_m = seed;
    err_m  = 0;
    bus.i_chk_start = 1'b1;
    bus.i_chk_seed  = seed;
    bus.i_chk_len   = len;
    @(negedge clk);
    bus.i_chk_start = 1'b0;
  endtask

  // Sends arr[from..to]; gap idle cycles between bytes; ends=1 expects done after 'to'.
  task automatic send_range(input int from, input int to, input int gap, input bit ends);
    logic [7:0] e;
    for (int i = from; i <= to; i++) begin
      bus.i_read_valid = 1'b1;
      bus.i_read_data  = arr[i];
      @(negedge clk);
      bus.i_read_valid = 1'b0;
      bus.i_read_data  = 8'h00;
      e = 8'(seed_m + 8'(i));
      if (arr[i] !== e && err_m < 255) err_m++;
      chk("live_err_cnt", bus.o_chk_err_cnt, err_m);
      if (i == to && ends) begin
        chk("done_at_last", bus.o_chk_done, 1);
      end else begin
        chk("no_early_done", bus.o_chk_done, 0);
        chk("pass_low_in_run", bus.o_chk_pass, 0);
      end
      if (i != to) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic status(input string tag, input bit pass, input bit tmo,
                        input int err, input int first);
    chk({tag, "_pass"},  bus.o_chk_pass, pass);
    chk({tag, "_tmo"},   bus.o_chk_timeout, tmo);
    chk({tag, "_err"},   bus.o_chk_err_cnt, err);
    chk({tag, "_first"}, bus.o_chk_first_err_idx, first);
  endtask

  task automatic after_done(input string tag, input bit pass);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, bus.o_chk_done, 0);
    chk({tag, "_ready"}, bus.o_chk_ready, 1);
    chk({tag, "_pass_hold"}, bus.o_chk_pass, pass);
  endtask

  initial begin
    int k;
    bit seen;
    bus.i_chk_start  = 1'b0;
    bus.i_chk_seed   = 8'h00;
    bus.i_chk_len    = 8'h00;
    bus.i_read_valid = 1'b0;
    bus.i_read_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_ready", bus.o_chk_ready, 1);
    chk("rst_done", bus.o_chk_done, 0);
    status("rst", 0, 0, 0, 0);

    // clean burst
    for (int i = 0; i < 8; i++) arr[i] = 8'(i);
    do_start(8'h00, 8'd8);
    chk("run_not_ready", bus.o_chk_ready, 0);
    send_range(0, 7, 2, 1);
    status("clean", 1, 0, 0, 0);
    after_done("clean", 1);

    // wrap across 0xFF
    for (int i = 0; i < 8; i++) arr[i] = 8'(8'hFC + i);
    do_start(8'hFC, 8'd8);
    send_range(0, 7, 1, 1);
    status("wrap", 1, 0, 0, 0);
    after_done("wrap", 1);

    arr[4] = 8'hFF;
    do_start(8'hFC, 8'd8);
    send_range(0, 7, 1, 1);
    status("wrap_bad", 0, 0, 1, 4);
    after_done("wrap_bad", 0);

    // multiple errors
    for (int i = 0; i < 8; i++) arr[i] = 8'(8'h10 + i);
    arr[2] = 8'h55;
    arr[6] = 8'hAA;
    do_start(8'h10, 8'd8);
    send_range(0, 7, 0, 1);
    status("multi", 0, 0, 2, 2);
    after_done("multi", 0);

    for (int i = 0; i < 8; i++) arr[i] = 8'(8'h90 + i);
    do_start(8'h10, 8'd8);
    send_range(0, 7, 0, 1);
    status("all_bad", 0, 0, 8, 0);
    after_done("all_bad", 0);

    // 255 bad bytes back to back: counter reaches all-ones without wrapping
    for (int i = 0; i < 255; i++) arr[i] = ~8'(i);
    do_start(8'h00, 8'd255);
    send_range(0, 254, 0, 1);
    status("len255", 0, 0, 255, 0);
    after_done("len255", 0);

    // timeout after 5 of 8 bytes
    for (int i = 0; i < 8; i++) arr[i] = 8'(8'h40 + i);
    do_start(8'h40, 8'd8);
    send_range(0, 4, 1, 0);
    k = 0;
    seen = 1'b0;
    for (int c = 1; c <= TO + 8; c++) begin
      @(negedge clk);
      if (bus.o_chk_done === 1'b1) begin
        k = c;
        seen = 1'b1;
        break;
      end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_latency", k, TO);
    status("tmo", 0, 1, 0, 0);
    after_done("tmo", 0);

    // byte exactly on the threshold cycle keeps the burst alive
    do_start(8'h40, 8'd8);
    send_range(0, 4, 0, 0);
    repeat (TO - 1) @(negedge clk);
    chk("thr_no_done", bus.o_chk_done, 0);
    send_range(5, 7, 0, 1);
    status("thr", 1, 0, 0, 0);
    after_done("thr", 1);

    // zero length clears the previous failing status
    arr[0] = 8'h00;
    do_start(8'h00, 8'd8);
    send_range(0, 0, 0, 0);
    rst = 1'b0;
    k = 0;
    for (int c = 1; c <= TO + 2; c++) begin
      @(negedge clk);
      if (bus.o_chk_done === 1'b1) begin
        k = c;
        break;
      end
    end
    chk("pre_len0_tmo_latency", k, TO);
    @(negedge clk);
    do_start(8'h33, 8'd0);
    chk("len0_done", bus.o_chk_done, 1);
    status("len0", 1, 0, 0, 0);
    after_done("len0", 1);

    // valid pulses in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      bus.i_read_valid = 1'b1;
      bus.i_read_data  = 8'hE7;
      @(negedge clk);
    end
    bus.i_read_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid_done", bus.o_chk_done, 0);
    chk("idle_valid_ready", bus.o_chk_ready, 1);
    status("idle_valid", 1, 0, 0, 0);

    // start with a simultaneous byte, then a second start mid-run
    for (int i = 0; i < 4; i++) arr[i] = 8'(8'h20 + i);
    bus.i_read_valid = 1'b1;
    bus.i_read_data  = 8'h55;
    do_start(8'h20, 8'd4);
    bus.i_read_valid = 1'b0;
    chk("start_byte_ignored", bus.o_chk_err_cnt, 0);
    send_range(0, 1, 0, 0);
    bus.i_chk_start = 1'b1;
    bus.i_chk_seed  = 8'h00;
    bus.i_chk_len   = 8'd1;
    @(negedge clk);
    bus.i_chk_start = 1'b0;
    chk("restart_ignored_done", bus.o_chk_done, 0);
    send_range(2, 3, 0, 1);
    status("restart_ign", 1, 0, 0, 0);
    after_done("restart_ign", 1);

    // reset mid-run
    for (int i = 0; i < 8; i++) arr[i] = 8'(i);
    arr[1] = 8'hC3;
    do_start(8'h00, 8'd8);
    send_range(0, 2, 0, 0);
    chk("pre_rst_err", bus.o_chk_err_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_ready", bus.o_chk_ready, 1);
    chk("mrst_done", bus.o_chk_done, 0);
    status("mrst", 0, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < TO + 4; c++) begin
      @(negedge clk);
      if (bus.o_chk_done !== 1'b0) seen = 1'b1;
    end
    chk("mrst_no_done", seen, 0);

    arr[1] = 8'h01;
    do_start(8'h00, 8'd8);
    send_range(0, 7, 2, 1);
    status("post_rst", 1, 0, 0, 0);
    after_done("post_rst", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
